// File: rtl/pkt_framer_pkg.sv
// Shared protocol definitions for the packet framer and its downstream tracker.
// Both stages rely on this one-hot state encoding so they agree on which beat is on the wire.
package pkt_framer_pkg;

   localparam int DEFAULT_DATA_W     = 8;
   localparam int DEFAULT_LEN_W      = 4;
   localparam int DEFAULT_GAP_CYCLES = 1;
   localparam int PKT_COUNT_W        = 8;

   localparam logic [4:0] STATE_IDLE = 5'b00001;
   localparam logic [4:0] STATE_HEAD = 5'b00010;
   localparam logic [4:0] STATE_DATA = 5'b00100;
   localparam logic [4:0] STATE_TAIL = 5'b01000;
   localparam logic [4:0] STATE_GAP  = 5'b10000;

   typedef enum logic [4:0] {
      S_IDLE = STATE_IDLE,
      S_HEAD = STATE_HEAD,
      S_DATA = STATE_DATA,
      S_TAIL = STATE_TAIL,
      S_GAP  = STATE_GAP
   } framer_state_t;

   // The head beat carries the length zero-extended, so the length field must fit in a data word.
   function automatic bit len_width_ok(input int len_w, input int data_w);
      return (len_w > 0) && (len_w <= data_w);
   endfunction

endpackage

// File: rtl/pkt_framer_if.sv
// Request, payload and framed-output signals of the packet framer.
// The master drives requests and payload and watches the framed beats; the framer is the slave.
interface pkt_framer_if
   import pkt_framer_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int LEN_W  = DEFAULT_LEN_W
);

   logic              req_valid;
   logic [LEN_W-1:0]  req_len;
   logic              req_ready;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic              out_head;
   logic              out_tail;
   logic [DATA_W-1:0] out_data;

   modport master (
      output req_valid, req_len, in_valid, in_data,
      input  req_ready, in_ready, out_valid, out_head, out_tail, out_data
   );

   modport slave (
      input  req_valid, req_len, in_valid, in_data,
      output req_ready, in_ready, out_valid, out_head, out_tail, out_data
   );

endinterface

// File: rtl/pkt_framer.sv
// Frames a length request plus raw payload words into head / data / tail beats with an XOR checksum.
// There is no output backpressure: out_valid only drops when the payload source is late.
module pkt_framer
   import pkt_framer_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int LEN_W      = DEFAULT_LEN_W,
   parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   pkt_framer_if.slave            bus,
   output logic                   busy,
   output logic [PKT_COUNT_W-1:0] pkt_count
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   if (!len_width_ok(LEN_W, DATA_W)) begin : g_bad_len_w
      $error("pkt_framer: LEN_W must be between 1 and DATA_W");
   end

   framer_state_t     state;
   logic [LEN_W-1:0]  remaining;
   logic [DATA_W-1:0] csum;
   logic [GAP_W-1:0]  gap_cnt;

   logic              out_valid_q;
   logic              out_head_q;
   logic              out_tail_q;
   logic [DATA_W-1:0] out_data_q;

   logic              req_ready_w;
   logic              in_ready_w;
   logic              req_fire;
   logic              in_fire;

   // Handshake readies are gated by reset so nothing is accepted on the edge that clears the framer.
   assign req_ready_w = (state == S_IDLE) & ~reset;
   assign in_ready_w  = ((state == S_HEAD) | (state == S_DATA)) & (remaining != '0) & ~reset;
   assign req_fire    = bus.req_valid & req_ready_w;
   assign in_fire     = bus.in_valid & in_ready_w;

   assign bus.req_ready = req_ready_w;
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_head  = out_head_q;
   assign bus.out_tail  = out_tail_q;
   assign bus.out_data  = out_data_q;
   assign busy          = (state != S_IDLE);

   // Each state names the beat currently on the output; the beat for the next state is registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         remaining   <= '0;
         csum        <= '0;
         gap_cnt     <= '0;
         pkt_count   <= '0;
         out_valid_q <= 1'b0;
         out_head_q  <= 1'b0;
         out_tail_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= 1'b0;
         out_head_q  <= 1'b0;
         out_tail_q  <= 1'b0;
         out_data_q  <= '0;

         case (state)
            S_IDLE: begin
               if (req_fire) begin
                  remaining   <= bus.req_len;
                  csum        <= '0;
                  out_valid_q <= 1'b1;
                  out_head_q  <= 1'b1;
                  out_data_q  <= DATA_W'(bus.req_len);
                  state       <= S_HEAD;
               end
            end

            S_HEAD, S_DATA: begin
               if (remaining == '0) begin
                  out_valid_q <= 1'b1;
                  out_tail_q  <= 1'b1;
                  out_data_q  <= csum;
                  pkt_count   <= pkt_count + 1'b1;
                  state       <= S_TAIL;
               end else begin
                  state <= S_DATA;
                  if (in_fire) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= bus.in_data;
                     remaining   <= remaining - 1'b1;
                     csum        <= csum ^ bus.in_data;
                  end
               end
            end

            S_TAIL: begin
               if (GAP_CYCLES > 0) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= S_GAP;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
